// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the host program/data loader: opcodes,
// error codes and the command FSM state encoding.
package cpu_loader_pkg;

    // Host command opcodes (first byte of every command)
    localparam logic [7:0] CMD_LOAD_IMEM = 8'h01;
    localparam logic [7:0] CMD_LOAD_DMEM = 8'h02;
    localparam logic [7:0] CMD_RUN       = 8'h03;
    localparam logic [7:0] CMD_HALT      = 8'h04;

    // Values reported on err_code while err is set
    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_BAD_OPCODE = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

    // Command FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_CNT_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DRAIN  = 3'd5
    } state_e;

endpackage

// File: rtl/cpu_loader_if.sv
// Byte-stream input, CPU external memory write ports and loader status,
// bundled so the loader and its surroundings share one connection.
interface cpu_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    logic [31:0] addr_ext;
    logic        wen_ext;
    logic [31:0] wdata_ext;

    logic [31:0] addr_ext_2;
    logic        wen_ext_2;
    logic [31:0] wdata_ext_2;

    logic        cpu_enable;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] words_loaded;

    // Loader side: consumes bytes, drives memories and status
    modport master (
        input  rx_data, rx_valid,
        output rx_ready,
        output addr_ext, wen_ext, wdata_ext,
        output addr_ext_2, wen_ext_2, wdata_ext_2,
        output cpu_enable, busy, err, err_code, words_loaded
    );

    // Host/CPU side: supplies bytes, observes memories and status
    modport slave (
        output rx_data, rx_valid,
        input  rx_ready,
        input  addr_ext, wen_ext, wdata_ext,
        input  addr_ext_2, wen_ext_2, wdata_ext_2,
        input  cpu_enable, busy, err, err_code, words_loaded
    );

endinterface

// File: rtl/cpu_loader_timeout.sv
// Inter-byte watchdog: counts idle cycles while armed and flags expiry
// once TIMEOUT_CYC consecutive cycles pass without an accepted byte.
module loader_timeout #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic kick,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] idle_cnt;

    // Count idle cycles; any accepted byte or leaving the armed states restarts it
    always_ff @(posedge clk) begin
        if (rst || !arm || kick) begin
            idle_cnt <= '0;
        end else if (idle_cnt != LAST) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // The TIMEOUT_CYC-th idle cycle is the one on which expiry is reported
    assign expired = arm && !kick && (idle_cnt == LAST);

endmodule

// File: rtl/cpu_loader.sv
// Host loader: assembles big-endian words from a byte stream, writes them
// into instruction or data memory through the CPU's external ports, and
// controls the CPU run enable with RUN/HALT commands.
module cpu_loader
    import cpu_loader_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE   = 32'h0,
    parameter logic [31:0] DMEM_BASE   = 32'h0,
    parameter int          IMEM_WORDS  = 512,
    parameter int          DMEM_WORDS  = 1024,
    parameter int          TIMEOUT_CYC = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    cpu_loader_if.master bus
);

    state_e      state;
    logic [15:0] word_cnt;
    logic [15:0] loaded;
    logic [31:0] ptr;
    logic [23:0] word_sr;
    logic [1:0]  byte_idx;
    logic        sel_dmem;
    logic        ovf;
    logic [17:0] drain_left;

    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_wen;
    logic        run_q;
    logic        err_q;
    logic [1:0]  err_code_q;

    logic        accept;
    logic        arm;
    logic        expired;
    logic [15:0] cnt_next;
    logic [31:0] word_full;
    logic [31:0] cap_words;

    // The WRITE cycle is the only one in which no byte can be taken
    assign bus.rx_ready = !rst && (state != ST_WRITE);
    assign accept       = bus.rx_valid && bus.rx_ready;
    assign arm          = (state == ST_CNT_HI) || (state == ST_CNT_LO) ||
                          (state == ST_DATA)   || (state == ST_DRAIN);
    assign cnt_next     = {word_cnt[15:8], bus.rx_data};
    assign word_full    = {word_sr, bus.rx_data};
    assign cap_words    = sel_dmem ? 32'(DMEM_WORDS) : 32'(IMEM_WORDS);

    loader_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .arm     (arm),
        .kick    (accept),
        .expired (expired)
    );

    // Command FSM with registered memory-port, run-enable and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            word_cnt   <= '0;
            loaded     <= '0;
            ptr        <= '0;
            word_sr    <= '0;
            byte_idx   <= '0;
            sel_dmem   <= 1'b0;
            ovf        <= 1'b0;
            drain_left <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            imem_wen   <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wen   <= 1'b0;
            run_q      <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            imem_wen <= 1'b0;
            dmem_wen <= 1'b0;

            if (expired) begin
                // Host went silent mid-command: drop any partial word
                err_q      <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
                run_q      <= 1'b0;
                state      <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            case (bus.rx_data)
                                CMD_LOAD_IMEM, CMD_LOAD_DMEM: begin
                                    // Halt the core before anything is written
                                    err_q      <= 1'b0;
                                    err_code_q <= ERR_NONE;
                                    run_q      <= 1'b0;
                                    loaded     <= '0;
                                    ovf        <= 1'b0;
                                    byte_idx   <= '0;
                                    sel_dmem   <= (bus.rx_data == CMD_LOAD_DMEM);
                                    ptr        <= (bus.rx_data == CMD_LOAD_DMEM) ?
                                                  DMEM_BASE : IMEM_BASE;
                                    state      <= ST_CNT_HI;
                                end
                                CMD_RUN: begin
                                    err_q      <= 1'b0;
                                    err_code_q <= ERR_NONE;
                                    run_q      <= 1'b1;
                                end
                                CMD_HALT: begin
                                    err_q      <= 1'b0;
                                    err_code_q <= ERR_NONE;
                                    run_q      <= 1'b0;
                                end
                                default: begin
                                    err_q      <= 1'b1;
                                    err_code_q <= ERR_BAD_OPCODE;
                                end
                            endcase
                        end
                    end

                    ST_CNT_HI: begin
                        if (accept) begin
                            word_cnt[15:8] <= bus.rx_data;
                            state          <= ST_CNT_LO;
                        end
                    end

                    ST_CNT_LO: begin
                        if (accept) begin
                            word_cnt <= cnt_next;
                            if (cnt_next == 16'd0) begin
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_DATA;
                                // Flag overflow up front; fitting words are still written
                                if ({16'h0, cnt_next} > cap_words) begin
                                    ovf        <= 1'b1;
                                    err_q      <= 1'b1;
                                    err_code_q <= ERR_OVERFLOW;
                                end
                            end
                        end
                    end

                    ST_DATA: begin
                        if (accept) begin
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                loaded <= loaded + 16'd1;
                                state  <= ST_WRITE;
                                if (sel_dmem) begin
                                    dmem_wen   <= 1'b1;
                                    dmem_addr  <= ptr;
                                    dmem_wdata <= word_full;
                                end else begin
                                    imem_wen   <= 1'b1;
                                    imem_addr  <= ptr;
                                    imem_wdata <= word_full;
                                end
                            end else begin
                                word_sr <= word_full[23:0];
                            end
                        end
                    end

                    ST_WRITE: begin
                        ptr <= ptr + 32'd4;
                        if (loaded == word_cnt) begin
                            state <= ST_IDLE;
                        end else if (ovf && ({16'h0, loaded} == cap_words)) begin
                            // Swallow the words that do not fit
                            drain_left <= {word_cnt - loaded, 2'b00};
                            state      <= ST_DRAIN;
                        end else begin
                            state <= ST_DATA;
                        end
                    end

                    ST_DRAIN: begin
                        if (accept) begin
                            drain_left <= drain_left - 18'd1;
                            if (drain_left == 18'd1) begin
                                state <= ST_IDLE;
                            end
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.addr_ext     = imem_addr;
    assign bus.wen_ext      = imem_wen;
    assign bus.wdata_ext    = imem_wdata;
    assign bus.addr_ext_2   = dmem_addr;
    assign bus.wen_ext_2    = dmem_wen;
    assign bus.wdata_ext_2  = dmem_wdata;
    assign bus.cpu_enable   = run_q;
    assign bus.busy         = !rst && (state != ST_IDLE);
    assign bus.err          = err_q;
    assign bus.err_code     = err_code_q;
    assign bus.words_loaded = loaded;

endmodule

// File: tb/tb_cpu_loader.sv
// Bench for cpu_loader: directed command scenarios plus random command
// streams, checked against a command-level model of the loader.
module tb_cpu_loader;

    localparam logic [31:0] IB = 32'h0000_0000;
    localparam logic [31:0] DB = 32'h0000_2000;
    localparam int          IW = 2;
    localparam int          DW = 4;
    localparam int          TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_loader_if bus ();

    cpu_loader #(
        .IMEM_BASE   (IB),
        .DMEM_BASE   (DB),
        .IMEM_WORDS  (IW),
        .DMEM_WORDS  (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        dmem;
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] cnt;
    } wr_t;

    int n_cmp = 0;
    int n_bad = 0;

    wr_t exp_q[$];
    wr_t obs_q[$];
    wr_t cmp_e;
    logic [7:0] cmd[$];

    logic        m_run = 1'b0;
    logic        m_err = 1'b0;
    logic [1:0]  m_code = 2'd0;
    logic [15:0] m_loaded = 16'd0;
    logic [31:0] last_ia = '0, last_id = '0, last_da = '0, last_dd = '0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
        end
    endtask

    // Per-cycle comparison of the memory ports against the expected write stream
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("ready_vs_write", 32'(bus.rx_ready), 32'(!(bus.wen_ext || bus.wen_ext_2)));
            chk("single_wen", 32'(bus.wen_ext & bus.wen_ext_2), 32'd0);
            if (bus.wen_ext || bus.wen_ext_2) begin
                obs_q.push_back('{bus.wen_ext_2,
                                  bus.wen_ext_2 ? bus.addr_ext_2 : bus.addr_ext,
                                  bus.wen_ext_2 ? bus.wdata_ext_2 : bus.wdata_ext,
                                  bus.words_loaded});
                chk("unexpected_write", 32'(exp_q.size() == 0), 32'd0);
                if (exp_q.size() != 0) begin
                    cmp_e = exp_q.pop_front();
                    chk("wr_port", 32'(bus.wen_ext_2), 32'(cmp_e.dmem));
                    if (cmp_e.dmem) begin
                        chk("wr_addr_d", bus.addr_ext_2, cmp_e.addr);
                        chk("wr_data_d", bus.wdata_ext_2, cmp_e.data);
                        last_da = cmp_e.addr;
                        last_dd = cmp_e.data;
                    end else begin
                        chk("wr_addr_i", bus.addr_ext, cmp_e.addr);
                        chk("wr_data_i", bus.wdata_ext, cmp_e.data);
                        last_ia = cmp_e.addr;
                        last_id = cmp_e.data;
                    end
                    chk("wr_count", 32'(bus.words_loaded), 32'(cmp_e.cnt));
                end
            end
            if (!bus.wen_ext) begin
                chk("hold_addr_i", bus.addr_ext, last_ia);
                chk("hold_data_i", bus.wdata_ext, last_id);
            end
            if (!bus.wen_ext_2) begin
                chk("hold_addr_d", bus.addr_ext_2, last_da);
                chk("hold_data_d", bus.wdata_ext_2, last_dd);
            end
        end
    end

    // Command-level model: derive expected writes and final status from cmd
    task automatic model_apply();
        logic [7:0]  op;
        logic [15:0] n;
        int          cap, nw;
        bit          d;
        op = cmd[0];
        if (op == 8'h01 || op == 8'h02) begin
            d   = (op == 8'h02);
            n   = {cmd[1], cmd[2]};
            cap = d ? DW : IW;
            nw  = (int'(n) < cap) ? int'(n) : cap;
            m_run  = 1'b0;
            m_err  = 1'b0;
            m_code = 2'd0;
            for (int i = 0; i < nw; i++) begin
                exp_q.push_back('{d, (d ? DB : IB) + 32'(4 * i),
                                  {cmd[3+4*i], cmd[4+4*i], cmd[5+4*i], cmd[6+4*i]},
                                  16'(i + 1)});
            end
            m_loaded = 16'(nw);
            if (int'(n) > cap) begin
                m_err  = 1'b1;
                m_code = 2'd2;
            end
        end else if (op == 8'h03) begin
            m_run = 1'b1; m_err = 1'b0; m_code = 2'd0;
        end else if (op == 8'h04) begin
            m_run = 1'b0; m_err = 1'b0; m_code = 2'd0;
        end else begin
            m_err = 1'b1; m_code = 2'd1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        k = 0;
        while (!bus.rx_ready && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("byte_accept", 32'(bus.rx_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input bit gaps);
        foreach (cmd[i]) begin
            send_byte(cmd[i]);
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic finish_cmd(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (bus.busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_run"}, 32'(bus.cpu_enable), 32'(m_run));
        chk({tag, "_err"}, 32'(bus.err), 32'(m_err));
        chk({tag, "_code"}, 32'(bus.err_code), 32'(m_code));
        chk({tag, "_loaded"}, 32'(bus.words_loaded), 32'(m_loaded));
    endtask

    task automatic set_cmd(input logic [7:0] b[]);
        cmd.delete();
        foreach (b[i]) cmd.push_back(b[i]);
    endtask

    task automatic build_random();
        int r, n;
        cmd.delete();
        r = $urandom_range(0, 9);
        if (r <= 6) begin
            cmd.push_back((r <= 3) ? 8'h01 : 8'h02);
            n = $urandom_range(0, 6);
            cmd.push_back(8'(n >> 8));
            cmd.push_back(8'(n));
            for (int i = 0; i < 4 * n; i++) cmd.push_back(8'($urandom));
        end else if (r == 7) begin
            cmd.push_back(8'h03);
        end else if (r == 8) begin
            cmd.push_back(8'h04);
        end else begin
            cmd.push_back(8'($urandom_range(5, 255)));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wen_i"}, 32'(bus.wen_ext), 32'd0);
        chk({tag, "_addr_i"}, bus.addr_ext, 32'd0);
        chk({tag, "_data_i"}, bus.wdata_ext, 32'd0);
        chk({tag, "_wen_d"}, 32'(bus.wen_ext_2), 32'd0);
        chk({tag, "_addr_d"}, bus.addr_ext_2, 32'd0);
        chk({tag, "_data_d"}, bus.wdata_ext_2, 32'd0);
        chk({tag, "_run"}, 32'(bus.cpu_enable), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_code"}, 32'(bus.err_code), 32'd0);
        chk({tag, "_loaded"}, 32'(bus.words_loaded), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.rx_ready), 32'd0);
        check_all_zero("rst");
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.rx_ready), 32'd1);
        chk_en = 1'b1;

        // Two IMEM words
        obs_q.delete();
        set_cmd('{8'h01, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78});
        model_apply();
        send_cmd(1'b0);
        finish_cmd("imem2");
        chk("imem2_nwr", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() == 2) begin
            chk("imem2_port0", 32'(obs_q[0].dmem), 32'd0);
            chk("imem2_addr0", obs_q[0].addr, 32'h0);
            chk("imem2_data0", obs_q[0].data, 32'hDEADBEEF);
            chk("imem2_addr1", obs_q[1].addr, 32'h4);
            chk("imem2_data1", obs_q[1].data, 32'h12345678);
        end
        chk("imem2_loaded", 32'(bus.words_loaded), 32'd2);

        // DMEM load, RUN, zero-length IMEM load
        obs_q.delete();
        set_cmd('{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h2A});
        model_apply();
        send_cmd(1'b0);
        finish_cmd("dmem1");
        chk("dmem1_nwr", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() == 1) begin
            chk("dmem1_port", 32'(obs_q[0].dmem), 32'd1);
            chk("dmem1_addr", obs_q[0].addr, DB);
            chk("dmem1_data", obs_q[0].data, 32'h0000002A);
        end
        set_cmd('{8'h03});
        model_apply();
        send_cmd(1'b0);
        chk("run_on", 32'(bus.cpu_enable), 32'd1);
        finish_cmd("run");
        obs_q.delete();
        set_cmd('{8'h01});
        model_apply();
        send_cmd(1'b0);
        chk("load_halts", 32'(bus.cpu_enable), 32'd0);
        set_cmd('{8'h00, 8'h00});
        send_cmd(1'b0);
        finish_cmd("zero_len");
        chk("zero_len_nwr", 32'(obs_q.size()), 32'd0);

        // Bad opcode, then RUN clears it
        set_cmd('{8'h7F});
        model_apply();
        send_cmd(1'b0);
        chk("bad_err", 32'(bus.err), 32'd1);
        chk("bad_code", 32'(bus.err_code), 32'd1);
        finish_cmd("bad");
        set_cmd('{8'h03});
        model_apply();
        send_cmd(1'b0);
        chk("clr_err", 32'(bus.err), 32'd0);
        chk("clr_run", 32'(bus.cpu_enable), 32'd1);
        finish_cmd("clr");

        // Overflow: 3 words into a 2-word IMEM
        obs_q.delete();
        set_cmd('{8'h01, 8'h00, 8'h03,
                  8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
                  8'h33, 8'h33, 8'h33, 8'h33});
        model_apply();
        send_cmd(1'b0);
        finish_cmd("ovf");
        chk("ovf_nwr", 32'(obs_q.size()), 32'd2);
        chk("ovf_code", 32'(bus.err_code), 32'd2);
        chk("ovf_loaded", 32'(bus.words_loaded), 32'd2);

        // Timeout after one data byte
        obs_q.delete();
        set_cmd('{8'h01, 8'h00, 8'h01, 8'hAA});
        send_cmd(1'b0);
        m_run = 1'b0; m_err = 1'b1; m_code = 2'd3; m_loaded = 16'd0;
        repeat (TO) @(negedge clk);
        chk("to_busy_last", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("to_busy_done", 32'(bus.busy), 32'd0);
        chk("to_code", 32'(bus.err_code), 32'd3);
        finish_cmd("to");
        chk("to_nwr", 32'(obs_q.size()), 32'd0);

        // Reset in the middle of the second word
        exp_q.push_back('{1'b0, IB, 32'hA1B2C3D4, 16'd1});
        set_cmd('{8'h01, 8'h00, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h11, 8'h22, 8'h33});
        send_cmd(1'b0);
        @(negedge clk);
        chk("mid_loaded", 32'(bus.words_loaded), 32'd1);
        rst = 1'b1;
        last_ia = '0; last_id = '0; last_da = '0; last_dd = '0;
        m_run = 1'b0; m_err = 1'b0; m_code = 2'd0; m_loaded = 16'd0;
        #1;
        chk("mid_rst_ready", 32'(bus.rx_ready), 32'd0);
        @(posedge clk);
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", 32'(bus.rx_ready), 32'd1);
        obs_q.delete();
        set_cmd('{8'h01, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE});
        model_apply();
        send_cmd(1'b0);
        finish_cmd("after_rst");
        chk("after_rst_nwr", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() == 1) begin
            chk("after_rst_addr", obs_q[0].addr, IB);
            chk("after_rst_data", obs_q[0].data, 32'hCAFEBABE);
        end

        // Random command stream
        for (int c = 0; c < 60; c++) begin
            build_random();
            model_apply();
            send_cmd(1'b1);
            finish_cmd("rnd");
        end

        repeat (3) @(negedge clk);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout at %0t: bench did not complete", $time);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule

// File: doc/cpu_loader.md
Name: cpu_loader

Overview:
- Upstream host-interface stage for the pipelined CPU top.
- Consumes a byte stream from the serial receiver and assembles 32-bit words. Writes each word into instruction or data memory through the CPU's external memory ports (addr_ext/wen_ext/wdata_ext and the _2 set).
- Drives the CPU run enable.
- Lets a host load a program and data image, start execution and halt it without touching the core.

Parameters:
- IMEM_BASE, 32'h0, byte address of the first instruction-memory word written.
- DMEM_BASE, 32'h0, byte address of the first data-memory word written.
- IMEM_WORDS, 512, instruction-memory capacity in words.
- DMEM_WORDS, 1024, data-memory capacity in words.
- TIMEOUT_CYC, 1000000, maximum idle cycles between bytes inside a command.

Ports:
- clk  in  1  clock
- rst  in  1  reset: one clock, synchronous, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte; a transfer occurs when rx_valid && rx_ready
- addr_ext  out  32  IMEM external byte address
- wen_ext  out  1  IMEM external write enable, 1-cycle pulse
- wdata_ext  out  32  IMEM external write word
- addr_ext_2  out  32  DMEM external byte address
- wen_ext_2  out  1  DMEM external write enable, 1-cycle pulse
- wdata_ext_2  out  32  DMEM external write word
- cpu_enable  out  1  CPU run enable
- busy  out  1  command in progress (state != IDLE)
- err  out  1  sticky error flag
- err_code  out  2  1 = bad opcode, 2 = overflow, 3 = timeout
- words_loaded  out  16  words written by the current/last LOAD

Behaviour:
- Reset values:
  - All outputs 0, rx_ready 0 while rst is high.
  - State IDLE.
  - First cycle after reset: rx_ready = 1.
- Command set (first byte in IDLE):
  - 0x01 LOAD_IMEM
  - 0x02 LOAD_DMEM
  - 0x03 RUN: cpu_enable <= 1
  - 0x04 HALT: cpu_enable <= 0
  - Any other byte: err = 1, err_code = 1, stay IDLE.
- Error clearing: accepting any valid opcode byte clears err and err_code in the same cycle.
- LOAD entry:
  - cpu_enable <= 0 on the cycle the opcode is accepted; the core is halted before any memory write.
  - words_loaded <= 0.
  - Address pointer <= IMEM_BASE or DMEM_BASE.
- LOAD sequence:
  - Two count bytes, N, big-endian (CNT_HI, CNT_LO).
  - Then N words, 4 bytes each, big-endian (first byte = bits 31:24).
- States: IDLE -> CNT_HI -> CNT_LO -> DATA (byte_idx 0..3) -> WRITE -> DATA or IDLE; DRAIN.
- N = 0: return to IDLE after CNT_LO; no write.
- Write timing:
  - The 4th byte of a word is accepted in cycle t.
  - In cycle t+1 (WRITE): the selected wen pulses high for exactly 1 cycle, with addr/wdata valid that cycle; rx_ready = 0; words_loaded increments.
  - Then the pointer advances by 4 and the FSM goes to DATA, or to IDLE if words_loaded == N.
- rx_ready = 1 in every state except WRITE.
- Only the selected memory port is driven. The other wen stays 0 and its addr/wdata hold their last values.
- Overflow (N > IMEM_WORDS or DMEM_WORDS):
  - err = 1, err_code = 2.
  - Words below capacity are written normally.
  - Remaining bytes are consumed in DRAIN without writes until 4*N data bytes are received, then IDLE.
- Timeout:
  - Inter-byte counter runs in CNT_HI, CNT_LO, DATA and DRAIN; it resets on each accepted byte.
  - Reaching TIMEOUT_CYC: err = 1, err_code = 3, partial word discarded, go to IDLE.
  - cpu_enable stays 0.
- RUN/HALT take effect on the cycle after acceptance. RUN while running and HALT while halted are no-ops.
- rst mid-command: immediate return to IDLE; the partial word is not written and cpu_enable = 0.

Decomposition:
- Package cpu_loader_pkg holds:
  - Opcode constants CMD_LOAD_IMEM, CMD_LOAD_DMEM, CMD_RUN, CMD_HALT.
  - FSM state enum.
  - Error-code constants.
- Sub-module loader_timeout holds the inter-byte timeout counter.
  - Inputs: clk, rst, arm, kick.
  - Output: expired.
  - Parameter: TIMEOUT_CYC.

Test Plan:
- Load two IMEM words: bytes 01 00 02 DE AD BE EF 12 34 56 78 -> wen_ext pulses twice:
  - addr 0x0 / data 0xDEADBEEF
  - addr 0x4 / data 0x12345678
  - words_loaded = 2, wen_ext_2 never high, busy falls after the 2nd write.
- DMEM load, then RUN, then LOAD_IMEM with count 0 (bytes 02 00 01 00 00 00 2A, 03, 01 00 00):
  - wen_ext_2 pulses with addr 0x0 / data 0x2A.
  - cpu_enable = 1 after RUN, drops to 0 on the 01 opcode, no IMEM write.
- Bad opcode 0x7F -> err = 1, err_code = 1. Following 03 -> err cleared, cpu_enable = 1.
- Overflow (IMEM_WORDS = 2), count 3 with 12 data bytes:
  - Exactly two wen_ext pulses.
  - err_code = 2.
  - All 12 data bytes accepted, then IDLE.
- Timeout (TIMEOUT_CYC = 16): send 01 00 01 AA then stall 16 cycles -> err_code = 3, IDLE, no write.
- rst asserted after 3 of 4 data bytes -> no wen pulse, all outputs 0, next clean load starts from base.
